// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU
// instructions. It sits beside the single-cycle ALU in the execute stage and
// produces one quotient bit per cycle using restoring shift-subtract. Signed
// operations run on operand magnitudes, and the sign is fixed up afterwards.
// Division by zero and signed overflow need no special case: the datapath
// already produces the RISC-V-mandated values for them.
//
// Ports
//   CLK          rising-edge clock
//   nRST         asynchronous active-low reset
//   start        request; accepted in IDLE or DONE when flush is low
//   op           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend     first operand, captured when the request is accepted
//   divisor      second operand, captured when the request is accepted
//   flush        synchronous abort; returns to IDLE without a done pulse
//   busy         high while the unit is in CALC or SIGN (pipeline stall)
//   done         one-cycle completion pulse
//   result       registered quotient or remainder, held between completions
//   div_by_zero  registered; divisor was zero for the completed operation
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quo;      // starts as |dividend|, ends as |quotient|
  logic [DATA_W-1:0] rem;      // partial remainder
  logic [DATA_W-1:0] dvs;      // |divisor|
  logic              sel_rem;  // 1 for REM/REMU
  logic              neg_quo;
  logic              neg_rem;
  logic              dvz;

  // Sign handling of the incoming operands. For the unsigned ops both flags
  // stay low, so the raw operands go straight through.
  logic              dvd_neg;
  logic              dvs_neg;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;

  assign dvd_neg = ~op[0] & dividend[DATA_W-1];
  assign dvs_neg = ~op[0] & divisor[DATA_W-1];
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

  // One restoring step. The shifted remainder is one bit wider than the
  // operands because it can reach 2*|divisor|-1. A zero divisor always
  // "fits", so the quotient becomes all ones and the remainder collects the
  // dividend bits. That is exactly the RISC-V divide-by-zero result.
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              fits;

  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign fits    = (shifted >= {1'b0, dvs});

  // Final sign fix-up, used in the SIGN state.
  logic [DATA_W-1:0] quo_final;
  logic [DATA_W-1:0] rem_final;

  assign quo_final = neg_quo ? (~quo + 1'b1) : quo;
  assign rem_final = neg_rem ? (~rem + 1'b1) : rem;

  // Single state machine. Every output is registered here. flush takes
  // precedence over any state activity and over a simultaneous start.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      sel_rem     <= 1'b0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      dvz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            quo     <= dvd_mag;
            rem     <= '0;
            dvs     <= dvs_mag;
            sel_rem <= op[1];
            // A zero divisor suppresses quotient negation so the result is
            // all ones for every op.
            neg_quo <= (dvd_neg ^ dvs_neg) & (divisor != '0);
            neg_rem <= dvd_neg;
            dvz     <= (divisor == '0);
            cnt     <= CNT_W'(DATA_W - 1);
            busy    <= 1'b1;
            state   <= CALC;
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          rem <= fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], fits};
          if (cnt == '0) begin
            state <= SIGN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        SIGN: begin
          result      <= sel_rem ? rem_final : quo_final;
          div_by_zero <= dvz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= DONE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
